// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and address decode helpers.
// Used by both the register-bank slave and the team's AXI-Lite master.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of byte-offset bits below the word index for a given data width.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi_lite_wr_join.sv
// Joins independently arriving AW and W beats. Each is captured and held
// until its partner shows up, then a single-cycle commit strobe is raised
// together with the captured address, data and strobes.
module axi_lite_wr_join
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    aclk_i,
    input  logic                    areset_i,
    input  logic [ADDR_WIDTH-1:0]   awaddr_i,
    input  logic                    awvalid_i,
    output logic                    awready_o,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wstrb_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    input  logic                    bvalid_i,
    output logic                    commit_o,
    output logic [ADDR_WIDTH-1:0]   cmt_addr_o,
    output logic [DATA_WIDTH-1:0]   cmt_data_o,
    output logic [DATA_WIDTH/8-1:0] cmt_strb_o
);

    logic                    aw_held_q, aw_held_d;
    logic                    w_held_q,  w_held_d;
    logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
    logic [DATA_WIDTH-1:0]   data_q,    data_d;
    logic [DATA_WIDTH/8-1:0] strb_q,    strb_d;

    // A pending B response blocks new beats so the response stays unambiguous.
    assign awready_o  = !aw_held_q && !bvalid_i;
    assign wready_o   = !w_held_q  && !bvalid_i;
    assign commit_o   = aw_held_q && w_held_q;
    assign cmt_addr_o = addr_q;
    assign cmt_data_o = data_q;
    assign cmt_strb_o = strb_q;

    // Capture each half on its handshake; release both on commit.
    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        if (commit_o) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (awvalid_i && awready_o) begin
            aw_held_d = 1'b1;
            addr_d    = awaddr_i;
        end
        if (wvalid_i && wready_o) begin
            w_held_d = 1'b1;
            data_d   = wdata_i;
            strb_d   = wstrb_i;
        end
    end

    // Hold flags; reset drops any half-collected transaction.
    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
        end
    end

    // Captured payload is only meaningful while its flag is set.
    always_ff @(posedge aclk_i) begin
        addr_q <= addr_d;
        data_q <= data_d;
        strb_q <= strb_d;
    end

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite register bank: NUM_REGS byte-strobed registers, independent
// read and write paths, contents exported as a flat bus with a write pulse.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [1:0]                     bresp,
    output logic                           bvalid,
    input  logic                           bready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    input  logic                           arvalid,
    output logic                           arready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic                           wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx
);

    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);

    // Word index taken from just above the byte-offset bits.
    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_LSB +: IDX_W];
    endfunction

    // In range only when the index exists and no higher address bit is set.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] hi;
        hi = a >> (ADDR_LSB + IDX_W);
        return (hi == '0) && (int'(addr_idx(a)) < NUM_REGS);
    endfunction

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  bvalid_q;
    logic [1:0]            bresp_q;
    logic                  rvalid_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;
    logic                  wr_pulse_q;
    logic [IDX_W-1:0]      wr_idx_q;

    logic                  commit;
    logic [ADDR_WIDTH-1:0] cmt_addr;
    logic [DATA_WIDTH-1:0] cmt_data;
    logic [STRB_W-1:0]     cmt_strb;
    logic                  cmt_ok;
    logic [IDX_W-1:0]      cmt_idx;
    logic                  ar_hs;

    axi_lite_wr_join #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_join (
        .aclk_i     (aclk),
        .areset_i   (areset),
        .awaddr_i   (awaddr),
        .awvalid_i  (awvalid),
        .awready_o  (awready),
        .wdata_i    (wdata),
        .wstrb_i    (wstrb),
        .wvalid_i   (wvalid),
        .wready_o   (wready),
        .bvalid_i   (bvalid_q),
        .commit_o   (commit),
        .cmt_addr_o (cmt_addr),
        .cmt_data_o (cmt_data),
        .cmt_strb_o (cmt_strb)
    );

    assign cmt_ok  = addr_ok(cmt_addr);
    assign cmt_idx = addr_idx(cmt_addr);
    assign arready = !rvalid_q;
    assign ar_hs   = arvalid && arready;

    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign wr_pulse = wr_pulse_q;
    assign wr_idx   = wr_idx_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    // Byte-merge the committed write into the addressed register.
    always_comb begin
        regs_d = regs_q;
        if (commit && cmt_ok) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (cmt_strb[k]) begin
                    regs_d[cmt_idx][k*8 +: 8] = cmt_data[k*8 +: 8];
                end
            end
        end
    end

    // Register array storage.
    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Write response and commit notification.
    always_ff @(posedge aclk) begin
        if (areset) begin
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            wr_pulse_q <= commit && cmt_ok;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= cmt_ok ? RESP_OKAY : RESP_SLVERR;
                if (cmt_ok) begin
                    wr_idx_q <= cmt_idx;
                end
            end else if (bvalid_q && bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Read path: sample the register before any same-edge write lands.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= addr_ok(araddr) ? regs_q[addr_idx(araddr)] : '0;
            rresp_q  <= addr_ok(araddr) ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Self-checking bench for the AXI-Lite register bank.
module tb_axi_lite_slave_regs;

    logic         aclk = 1'b0;
    logic         areset;
    logic [31:0]  awaddr, wdata, araddr;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready;
    logic [1:0]   bresp, rresp;
    logic         bvalid, bready, arvalid, arready, rvalid, rready;
    logic [31:0]  rdata;
    logic [255:0] reg_out;
    logic         wr_pulse;
    logic [2:0]   wr_idx;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] model [8];
    logic [31:0] exp_d_q [$];
    logic [1:0]  exp_r_q [$];

    axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8)) dut (
        .aclk(aclk), .areset(areset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_out(reg_out), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog elapsed, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int k = 0; k < 4; k++) if (s[k]) r[k*8 +: 8] = n[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [255:0] model_flat();
        logic [255:0] f;
        for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
        return f;
    endfunction

    function automatic logic [31:0] reg_of(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic drive_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output bit saw_pulse);
        bit aw_go, w_go, got;
        saw_pulse = 0; resp = 2'b11; got = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            tick();
            if (aw_go) awvalid = 0;
            if (w_go)  wvalid = 0;
        end
        for (int i = 0; i < 50 && !got; i++) begin
            if (wr_pulse) saw_pulse = 1;
            if (bvalid) begin resp = bresp; got = 1; end
            tick();
        end
        bready = 0;
        if (!got || awvalid || wvalid) begin
            n_vec++; n_err++;
            $display("FAIL write_timeout addr=%h got=no_bvalid required=bvalid", a);
            awvalid = 0; wvalid = 0;
        end
    endtask

    task automatic drive_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                              output int lat);
        bit go;
        lat = -1; d = 'x; resp = 'x;
        araddr = a; arvalid = 1; rready = 1;
        for (int i = 0; i < 50 && arvalid; i++) begin
            go = arready;
            tick();
            if (go) arvalid = 0;
        end
        for (int i = 0; i < 50 && lat < 0; i++) begin
            if (rvalid) begin d = rdata; resp = rresp; lat = i; end
            tick();
        end
        rready = 0;
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL read_timeout addr=%h got=no_rvalid required=rvalid", a);
            arvalid = 0;
        end
    endtask

    task automatic test_reset();
        areset = 1; awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        repeat (3) tick();
        areset = 0;
        for (int i = 0; i < 8; i++) model[i] = 0;
        n_vec++; if ({awready, wready, arready} !== 3'b111) begin n_err++;
            $display("FAIL reset_ready got=%b required=111", {awready, wready, arready}); end
        n_vec++; if ({bvalid, rvalid, wr_pulse} !== 3'b000) begin n_err++;
            $display("FAIL reset_valids got=%b required=000", {bvalid, rvalid, wr_pulse}); end
        n_vec++; if (reg_out !== 256'd0) begin n_err++;
            $display("FAIL reset_regs got=%h required=0", reg_out); end
        n_vec++; if ({bresp, rresp, rdata, wr_idx} !== '0) begin n_err++;
            $display("FAIL reset_outputs got=%h required=0", {bresp, rresp, rdata, wr_idx}); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d; logic [1:0] r; int lat;
        awaddr = 32'h04; wdata = 32'hDEADBEEF; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        n_vec++; if (!(awready && wready)) begin n_err++;
            $display("FAIL sc_ready got=%b required=11", {awready, wready}); end
        tick();
        awvalid = 0; wvalid = 0;
        n_vec++; if (bvalid !== 1'b0) begin n_err++;
            $display("FAIL sc_bvalid_early got=%b required=0", bvalid); end
        tick();
        model[1] = 32'hDEADBEEF;
        n_vec++; if ({bvalid, bresp} !== 3'b100) begin n_err++;
            $display("FAIL sc_bresp got=%b required=100", {bvalid, bresp}); end
        n_vec++; if ({wr_pulse, wr_idx} !== 4'b1001) begin n_err++;
            $display("FAIL sc_pulse got=%b/%0d required=1/1", wr_pulse, wr_idx); end
        n_vec++; if (reg_of(1) !== 32'hDEADBEEF) begin n_err++;
            $display("FAIL sc_reg1 got=%h required=deadbeef", reg_of(1)); end
        bready = 1; tick(); bready = 0;
        n_vec++; if ({bvalid, wr_pulse} !== 2'b00) begin n_err++;
            $display("FAIL sc_after_b got=%b required=00", {bvalid, wr_pulse}); end
        exp_d_q.push_back(model[1]); exp_r_q.push_back(2'b00);
        drive_read(32'h04, d, r, lat);
        n_vec++; if (d !== exp_d_q.pop_front()) begin n_err++;
            $display("FAIL sc_rdata got=%h required=%h", d, model[1]); end
        n_vec++; if (r !== exp_r_q.pop_front() || lat !== 0) begin n_err++;
            $display("FAIL sc_rresp_lat got=%b/%0d required=00/0", r, lat); end
    endtask

    task automatic test_w_first();
        logic [1:0] r; bit p; bit got;
        drive_write(32'h08, 32'hAABBCCDD, 4'hF, r, p);
        model[2] = 32'hAABBCCDD;
        n_vec++; if (r !== 2'b00) begin n_err++; $display("FAIL wf_preload got=%b required=00", r); end
        wdata = 32'h11223344; wstrb = 4'h5; wvalid = 1;
        tick();
        wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if ({wready, awready, bvalid} !== 3'b010) begin n_err++;
                $display("FAIL wf_hold_%0d got=%b required=010", i, {wready, awready, bvalid}); end
            if (i < 2) tick();
        end
        awaddr = 32'h08; awvalid = 1;
        tick();
        awvalid = 0; bready = 1; got = 0; r = 2'b11;
        for (int i = 0; i < 20 && !got; i++) begin
            if (bvalid) begin got = 1; r = bresp; end
            tick();
        end
        bready = 0;
        model[2] = merge(model[2], 32'h11223344, 4'h5);
        n_vec++; if (!got || r !== 2'b00) begin n_err++;
            $display("FAIL wf_bresp got=%b/%b required=1/00", got, r); end
        n_vec++; if (reg_of(2) !== 32'hAA22CC44 || reg_of(2) !== model[2]) begin n_err++;
            $display("FAIL wf_reg2 got=%h required=aa22cc44", reg_of(2)); end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; bit p; logic [31:0] d; int lat;
        drive_write(32'h20, 32'h12345678, 4'hF, r, p);
        n_vec++; if (r !== 2'b10 || p !== 1'b0) begin n_err++;
            $display("FAIL oor_write got=%b/pulse%b required=10/pulse0", r, p); end
        drive_write(32'h4000_0004, 32'h0BADF00D, 4'hF, r, p);
        n_vec++; if (r !== 2'b10 || p !== 1'b0) begin n_err++;
            $display("FAIL oor_high got=%b/pulse%b required=10/pulse0", r, p); end
        n_vec++; if (reg_out !== model_flat()) begin n_err++;
            $display("FAIL oor_regs got=%h required=%h", reg_out, model_flat()); end
        exp_d_q.push_back(32'h0); exp_r_q.push_back(2'b10);
        drive_read(32'h20, d, r, lat);
        n_vec++; if (d !== exp_d_q.pop_front() || r !== exp_r_q.pop_front()) begin n_err++;
            $display("FAIL oor_read got=%h/%b required=0/10", d, r); end
        drive_write(32'h1F, 32'hCAFE0007, 4'h3, r, p);
        model[7] = merge(model[7], 32'hCAFE0007, 4'h3);
        n_vec++; if (r !== 2'b00 || reg_of(7) !== model[7]) begin n_err++;
            $display("FAIL offset_ignored got=%b/%h required=00/%h", r, reg_of(7), model[7]); end
    endtask

    task automatic test_b_backpressure();
        bit got;
        awaddr = 32'h14; wdata = 32'h55AA55AA; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
        tick(); awvalid = 0; wvalid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin if (bvalid) got = 1; else tick(); end
        model[5] = 32'h55AA55AA;
        awaddr = 32'h18; awvalid = 1;
        for (int i = 0; i < 5; i++) begin
            n_vec++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin n_err++;
                $display("FAIL bp_stall_%0d got=%b required=10000", i, {bvalid, bresp, awready, wready}); end
            tick();
        end
        bready = 1; tick(); bready = 0;
        n_vec++; if ({bvalid, awready} !== 2'b01) begin n_err++;
            $display("FAIL bp_release got=%b required=01", {bvalid, awready}); end
        tick(); awvalid = 0;
        n_vec++; if ({awready, wready} !== 2'b01) begin n_err++;
            $display("FAIL bp_aw_held got=%b required=01", {awready, wready}); end
        wdata = 32'h66666666; wstrb = 4'hF; wvalid = 1; tick(); wvalid = 0;
        bready = 1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin if (bvalid) got = 1; tick(); end
        bready = 0;
        model[6] = 32'h66666666;
        n_vec++; if (!got || reg_of(6) !== model[6] || reg_of(5) !== model[5]) begin n_err++;
            $display("FAIL bp_second got=%h/%h required=%h/%h", reg_of(5), reg_of(6), model[5], model[6]); end
    endtask

    task automatic test_r_backpressure();
        logic [1:0] r; bit p; logic [31:0] held; bit got;
        drive_write(32'h0C, 32'h1, 4'hF, r, p);
        model[3] = 32'h1;
        araddr = 32'h0C; arvalid = 1; rready = 0;
        tick(); arvalid = 0;
        held = rdata;
        n_vec++; if (held !== model[3]) begin n_err++;
            $display("FAIL rbp_data got=%h required=%h", held, model[3]); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({rvalid, arready} !== 2'b10 || rdata !== held) begin n_err++;
                $display("FAIL rbp_stall_%0d got=%b/%h required=10/%h", i, {rvalid, arready}, rdata, held); end
        end
        rready = 1; tick(); rready = 0;
        n_vec++; if ({rvalid, arready} !== 2'b01) begin n_err++;
            $display("FAIL rbp_release got=%b required=01", {rvalid, arready}); end
        awaddr = 32'h0C; wdata = 32'h2; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        tick(); awvalid = 0; wvalid = 0;
        araddr = 32'h0C; arvalid = 1;
        tick(); arvalid = 0;
        model[3] = 32'h2;
        n_vec++; if (rdata !== 32'h1 || rvalid !== 1'b1) begin n_err++;
            $display("FAIL same_edge_rdata got=%h required=00000001", rdata); end
        n_vec++; if (reg_of(3) !== model[3]) begin n_err++;
            $display("FAIL same_edge_reg got=%h required=%h", reg_of(3), model[3]); end
        rready = 1; bready = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin if (bvalid) got = 1; tick(); end
        rready = 0; bready = 0;
    endtask

    task automatic test_reset_mid();
        bit got;
        awaddr = 32'h00; awvalid = 1; tick(); awvalid = 0;
        araddr = 32'h04; arvalid = 1; rready = 0; tick(); arvalid = 0;
        n_vec++; if ({awready, rvalid} !== 2'b01) begin n_err++;
            $display("FAIL rm_setup got=%b required=01", {awready, rvalid}); end
        areset = 1; tick(); areset = 0;
        for (int i = 0; i < 8; i++) model[i] = 0;
        n_vec++; if ({awready, wready, arready, bvalid, rvalid, wr_pulse} !== 6'b111000) begin n_err++;
            $display("FAIL rm_flags got=%b required=111000", {awready, wready, arready, bvalid, rvalid, wr_pulse}); end
        n_vec++; if (reg_out !== model_flat() || rdata !== 32'h0) begin n_err++;
            $display("FAIL rm_regs got=%h/%h required=0/0", reg_out, rdata); end
        wdata = 32'hFFFFFFFF; wstrb = 4'hF; wvalid = 1; tick(); wvalid = 0;
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (bvalid !== 1'b0) begin n_err++;
                $display("FAIL rm_aw_discarded_%0d got=%b required=0", i, bvalid); end
            tick();
        end
        awaddr = 32'h00; awvalid = 1; tick(); awvalid = 0;
        bready = 1; got = 0;
        for (int i = 0; i < 10 && !got; i++) begin if (bvalid) got = 1; tick(); end
        bready = 0;
        model[0] = 32'hFFFFFFFF;
        n_vec++; if (!got || reg_of(0) !== model[0]) begin n_err++;
            $display("FAIL rm_recover got=%h required=%h", reg_of(0), model[0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, d, rd; logic [3:0] s; logic [1:0] r; bit p; int lat; bit ok;
        for (int n = 0; n < 12; n++) begin
            a = (n % 5 == 4) ? 32'h20 + 32'($urandom_range(0, 7) * 4) : 32'($urandom_range(0, 7) * 4);
            d = $urandom; s = 4'($urandom_range(0, 15));
            ok = (a >> 5) == 0;
            exp_r_q.push_back(ok ? 2'b00 : 2'b10);
            drive_write(a, d, s, r, p);
            if (ok) model[a[4:2]] = merge(model[a[4:2]], d, s);
            n_vec++; if (r !== exp_r_q.pop_front() || p !== (ok ? 1'b1 : 1'b0)) begin n_err++;
                $display("FAIL b2b_write_%0d got=%b/pulse%b required=ok%b", n, r, p, ok); end
        end
        for (int i = 0; i < 8; i++) begin
            exp_d_q.push_back(model[i]); exp_r_q.push_back(2'b00);
            drive_read(32'(i * 4), rd, r, lat);
            n_vec++; if (rd !== exp_d_q.pop_front() || r !== exp_r_q.pop_front()) begin n_err++;
                $display("FAIL b2b_read_%0d got=%h/%b required=%h/00", i, rd, r, model[i]); end
        end
        n_vec++; if (reg_out !== model_flat()) begin n_err++;
            $display("FAIL b2b_regs got=%h required=%h", reg_out, model_flat()); end
    endtask

    initial begin
        test_reset();
        test_same_cycle();
        test_w_first();
        test_out_of_range();
        test_b_backpressure();
        test_r_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite slave (responder) exposing a bank of NUM_REGS read/write 32-bit-style registers to an AXI-Lite master. It accepts AW and W independently in either order and buffers each until its partner arrives. It then commits the byte-strobed write and returns a B response; reads return registered data on R. It sits at the far end of the bus from the team's AXI-Lite master and drives the register contents to user logic as a flat bus.

Parameters:
ADDR_WIDTH, 32, AXI address width
DATA_WIDTH, 32, data width; must be a multiple of 8
NUM_REGS, 8, number of registers; must be >= 2; index width IDX_W = $clog2(NUM_REGS)

Ports:
aclk  in  1  global clock
areset  in  1  synchronous active-high reset
awaddr  in  ADDR_WIDTH  write address
awvalid  in  1  write address valid
awready  out  1  slave ready for address
wdata  in  DATA_WIDTH  write data
wstrb  in  DATA_WIDTH/8  byte strobes
wvalid  in  1  write data valid
wready  out  1  slave ready for data
bresp  out  2  write response
bvalid  out  1  write response valid
bready  in  1  master ready for response
araddr  in  ADDR_WIDTH  read address
arvalid  in  1  read address valid
arready  out  1  slave ready for read address
rdata  out  DATA_WIDTH  read data
rresp  out  2  read response
rvalid  out  1  read data valid
rready  in  1  master ready for read data
reg_out  out  NUM_REGS*DATA_WIDTH  register contents; reg i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse  out  1  1-cycle pulse when a register write commits
wr_idx  out  IDX_W  index of the committed register; valid with wr_pulse

Behaviour:
- Reset: synchronous and active-high on aclk. While reset is asserted, all registers, bvalid, rvalid, wr_pulse, aw_held and w_held = 0; bresp, rresp, rdata and wr_idx = 0.
- Reset mid-transaction discards all held, pending and in-flight beats; no register changes.
- Decode: word index = addr[ADDR_LSB +: IDX_W], where ADDR_LSB = $clog2(DATA_WIDTH/8). Low byte-offset bits are ignored.
  - The address is out of range if index >= NUM_REGS, or if any address bit above ADDR_LSB+IDX_W is nonzero.
- Responses: OKAY = 2'b00, SLVERR = 2'b10.
- Write path:
  - awready = !aw_held && !bvalid. wready = !w_held && !bvalid. Both are combinational from registered flags, so both are 1 after reset.
  - AW handshake latches awaddr and sets aw_held. W handshake latches wdata/wstrb and sets w_held. AW and W may arrive in any order, in the same cycle, or many cycles apart.
  - Commit happens in the first cycle where aw_held && w_held. At that clock edge:
    - For an in-range address, each byte k with wstrb[k]=1 is updated; other bytes are unchanged. wstrb = 0 leaves the register unchanged but still returns OKAY.
    - bvalid <= 1; bresp <= OKAY, or SLVERR if out of range (no register is modified).
    - wr_pulse <= 1 and wr_idx <= index, in range only.
    - aw_held and w_held are cleared.
  - Latency: AW and W handshaking in cycle N gives commit at edge N+1 and bvalid high from cycle N+2.
  - bvalid holds with a stable bresp until the bvalid && bready edge. No new AW or W is accepted while bvalid = 1.
- Read path:
  - arready = !rvalid.
  - On the AR handshake edge: rdata <= register[index] (0 if out of range); rresp <= OKAY or SLVERR; rvalid <= 1.
  - rvalid, rdata and rresp are held stable until the rvalid && rready edge.
  - Read latency is 1 cycle from the AR handshake.
  - The read and write paths are fully independent.
- Simultaneous events: if an AR handshake and a write commit to the same register share an edge, rdata returns the pre-write value.
- reg_out is a direct view of the register array and updates the cycle after commit.
- wr_pulse is high for exactly one cycle per committed in-range write.

Decomposition:
- Shared package axi_lite_pkg holds: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11. It also holds the ADDR_LSB computation helper; the team's AXI-Lite master uses the same response constants.
- One natural sub-module: axi_lite_wr_join. It holds the independent AW/W capture flags, the latched addr/data/strb, and the commit-strobe generation.
- The register array and the read path stay in the top module.

Test Plan:
- AW+W same cycle, addr 0x04, wdata 0xDEADBEEF, wstrb 0xF -> bvalid in cycle N+2 with bresp 00; wr_pulse=1, wr_idx=1; reg 1 = 0xDEADBEEF; a read of 0x04 returns 0xDEADBEEF, rresp 00, one cycle after AR.
- W first, then AW 3 cycles later (addr 0x08, data 0x11223344, strb 0x5) on reg 2 preloaded with 0xAABBCCDD -> reg 2 = 0xAA22CC44. wready is 0 while data is held.
- Out-of-range write to 0x20 (NUM_REGS=8) -> bresp 10, no wr_pulse, all registers unchanged. Read of 0x20 -> rdata 0, rresp 10.
- bready held low for 5 cycles -> bvalid and bresp stable; awready and wready stay 0. A second AW presented meanwhile is accepted only after the B handshake.
- rready held low for 4 cycles -> rvalid and rdata stable, arready = 0. Same-edge read and write to reg 3 (old value 0x1, new value 0x2) -> rdata = 0x1.
- areset asserted with aw_held=1 and rvalid=1 -> next cycle all flags, valids and registers are 0, and awready/wready/arready are 1.
